// File: rtl/morse_keyer.sv
// Morse key front end: 2-flop synchronizer, debounce filter and a press/gap
// classifier that emits registered dot, dash and letter_end pulses.
module morse_keyer #(
    parameter int DB_CYCLES   = 4,
    parameter int DASH_CYCLES = 12,
    parameter int GAP_CYCLES  = 24,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic dot_o,
    output logic dash_o,
    output logic letter_end_o,
    output logic pressed_o,
    output logic busy_o
);

    // state | meaning
    // IDLE  | no symbol in progress, waiting for a debounced press
    // PRESS | key held, press length accumulating
    // GAP   | key released after a symbol, timing the inter-letter gap
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic               key_db_q, key_db_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               dot_q, dot_d;
    logic               dash_q, dash_d;
    logic               le_q, le_d;
    logic [CNT_W-1:0]   db_inc, gap_inc;

    assign db_inc  = db_cnt_q + CNT_W'(1);
    assign gap_inc = gap_cnt_q + CNT_W'(1);

    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (s2_q != key_db_q) begin
            if (db_inc == CNT_W'(DB_CYCLES)) begin
                key_db_d = s2_q;
            end else begin
                db_cnt_d = db_inc;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        dot_d       = 1'b0;
        dash_d      = 1'b0;
        le_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_db_q) begin
                    state_d     = PRESS;
                    press_cnt_d = CNT_W'(1);
                end
            end
            PRESS: begin
                if (key_db_q) begin
                    // saturate so a very long hold cannot wrap into a dot
                    if (press_cnt_q != '1) press_cnt_d = press_cnt_q + CNT_W'(1);
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    if (press_cnt_q < CNT_W'(DASH_CYCLES)) dot_d = 1'b1;
                    else                                   dash_d = 1'b1;
                end
            end
            GAP: begin
                if (key_db_q) begin
                    state_d     = PRESS;
                    press_cnt_d = CNT_W'(1);
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == CNT_W'(GAP_CYCLES)) begin
                        le_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            key_db_q    <= 1'b0;
            db_cnt_q    <= '0;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            dot_q       <= 1'b0;
            dash_q      <= 1'b0;
            le_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= key_i;
            s2_q        <= s1_q;
            key_db_q    <= key_db_d;
            db_cnt_q    <= db_cnt_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            dot_q       <= dot_d;
            dash_q      <= dash_d;
            le_q        <= le_d;
        end
    end

    assign dot_o        = dot_q;
    assign dash_o       = dash_q;
    assign letter_end_o = le_q;
    assign pressed_o    = key_db_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and timings.
module tb_morse_keyer;
    localparam int DB    = 4;
    localparam int DASHC = 12;
    localparam int GAPC  = 24;
    localparam int MAXC  = 255;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic key_i = 1'b0;
    logic dot_o, dash_o, letter_end_o, pressed_o, busy_o;

    morse_keyer #(.DB_CYCLES(DB), .DASH_CYCLES(DASHC), .GAP_CYCLES(GAPC), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i),
        .dot_o(dot_o), .dash_o(dash_o), .letter_end_o(letter_end_o),
        .pressed_o(pressed_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_dot = 0, n_dash = 0, n_le = 0, last_dot = -1, last_le = -1;
    bit rawh[$];
    bit dbh[$];
    bit mdb = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // raw sample k edges back, k=1 is the newest
    function automatic bit rget(input int k);
        if (k > rawh.size()) return 1'b0;
        return rawh[rawh.size() - k];
    endfunction

    // debounced level k edges back, k=0 is the newest
    function automatic bit dget(input int k);
        if (k >= dbh.size()) return 1'b0;
        return dbh[dbh.size() - 1 - k];
    endfunction

    initial begin
        bit k, r, flip, e_dot, e_dash, e_le, e_pr, e_busy, any1;
        int len;
        forever begin
            @(posedge clk_i);
            k = key_i;
            r = rst_i;
            cyc++;
            e_dot = 0; e_dash = 0; e_le = 0; e_pr = 0; e_busy = 0;
            if (r) begin
                rawh.delete();
                dbh.delete();
                mdb = 1'b0;
            end else begin
                rawh.push_back(k);
                if (rawh.size() > 64) void'(rawh.pop_front());
                // accept a new level once the synchronized key has disagreed DB times in a row
                flip = 1'b1;
                for (int i = 3; i <= DB + 2; i++) if (rget(i) == mdb) flip = 1'b0;
                if (flip) mdb = ~mdb;
                dbh.push_back(mdb);
                if (dbh.size() > 400) void'(dbh.pop_front());
                e_pr = mdb;
                if (dget(1) == 1'b0 && dget(2) == 1'b1) begin
                    len = 0;
                    while (len < MAXC && dget(2 + len)) len++;
                    if (len < DASHC) e_dot = 1'b1;
                    else             e_dash = 1'b1;
                end
                any1 = 1'b0;
                for (int i = 1; i <= GAPC + 1; i++) if (dget(i)) any1 = 1'b1;
                e_busy = any1;
                e_le = !any1 && dget(GAPC + 2);
            end
            #1;
            chk("dot", dot_o, e_dot);
            chk("dash", dash_o, e_dash);
            chk("letter_end", letter_end_o, e_le);
            chk("pressed", pressed_o, e_pr);
            chk("busy", busy_o, e_busy);
            if (dot_o)        begin n_dot++;  last_dot = cyc; end
            if (dash_o)       n_dash++;
            if (letter_end_o) begin n_le++;   last_le = cyc;  end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic clr();
        n_dot = 0; n_dash = 0; n_le = 0; last_dot = -1; last_le = -1;
    endtask

    task automatic press(input int hi, input int lo);
        key_i = 1'b1;
        tick(hi);
        key_i = 1'b0;
        tick(lo);
    endtask

    initial begin
        int rel, hi, lo;
        tick(3);
        chk("rst_dot", dot_o, 0);
        chk("rst_dash", dash_o, 0);
        chk("rst_le", letter_end_o, 0);
        chk("rst_pressed", pressed_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        tick(5);

        // 5-cycle press: one dot DB+3 edges after release, letter_end 24 later
        clr();
        key_i = 1'b1;
        tick(5);
        key_i = 1'b0;
        rel = cyc;
        tick(40);
        chk("s1_dots", n_dot, 1);
        chk("s1_dashes", n_dash, 0);
        chk("s1_dot_time", last_dot, rel + DB + 3);
        chk("s1_le_count", n_le, 1);
        chk("s1_le_time", last_le, last_dot + 24);

        clr(); press(12, 40);
        chk("p12_dash", n_dash, 1);
        chk("p12_dot", n_dot, 0);
        clr(); press(11, 40);
        chk("p11_dot", n_dot, 1);
        chk("p11_dash", n_dash, 0);

        clr(); press(3, 20);
        chk("glitch_dot", n_dot + n_dash + n_le, 0);
        clr();
        key_i = 1'b1; tick(8);
        key_i = 1'b0; tick(3);
        key_i = 1'b1; tick(9);
        key_i = 1'b0; tick(40);
        chk("lowglitch_dash", n_dash, 1);
        chk("lowglitch_dot", n_dot, 0);

        clr(); press(5, 10); press(14, 40);
        chk("seq_dot", n_dot, 1);
        chk("seq_dash", n_dash, 1);
        chk("seq_le", n_le, 1);

        // reset in the middle of a press aborts it
        clr();
        key_i = 1'b1;
        tick(DB + 2 + 6);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk("abort_outs", {dot_o, dash_o, letter_end_o, pressed_o, busy_o}, 0);
        tick(2);
        key_i = 1'b0;
        tick(40);
        chk("abort_pulses", n_dot + n_dash + n_le, 0);

        clr(); press(300, 40);
        chk("long_dash", n_dash, 1);
        chk("long_dot", n_dot, 0);

        for (int i = 0; i < 40; i++) begin
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 35);
            if ($urandom_range(0, 9) == 0) begin
                key_i = 1'b1;
                tick(hi);
                rst_i = 1'b1;
                tick(1);
                rst_i = 1'b0;
                key_i = 1'b0;
                tick(lo);
            end else begin
                press(hi, lo);
            end
        end
        tick(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
